// File: rtl/harmonic_scheduler.sv
// Harmonic sweep sequencer: walks the harmonic index once per sample tick, weights each
// sample by a decaying level, accumulates, and emits one saturated mix. Optional: ODD_HARMONIC_EN.
module harmonic_scheduler #(
    parameter int NUM_HARM    = 64,
    parameter int LUT_LATENCY = 2,
    parameter int ACC_W       = 32,
    parameter int OUT_SHIFT   = 10
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Sample_Tick,
    input  logic [7:0]         i_Harm_Count,
    input  logic [7:0]         i_Decay,
    input  logic               i_Odd_Only,
    input  logic               i_Sample_Ready,
    input  logic signed [15:0] i_Sample_Value,
    input  logic               i_Freq_Too_High,
    output logic [7:0]         o_Harmonic,
    output logic               o_Next_Sample,
    output logic signed [15:0] o_Mix,
    output logic               o_Mix_Valid,
    output logic               o_Overrun
);

    localparam int CNT_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
    localparam logic signed [ACC_W-1:0] MAX16 = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN16 = -ACC_W'(32768);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SETTLE,
        MAC,
        ADVANCE,
        PULSE,
        FINISH
    } state_t;

    state_t state, next_state;

    logic signed [ACC_W-1:0] acc;
    logic [7:0]              level;
    logic [7:0]              count_lat;
    logic [7:0]              decay_lat;
    logic [CNT_W-1:0]        settle_cnt;
    logic signed [15:0]      sample_reg;
    logic                    too_high_reg;
    logic                    terminate;

    logic [7:0]              eff_count;
    logic signed [24:0]      product;
    logic signed [ACC_W-1:0] product_ext;
    logic [7:0]              level_dec;
    logic [7:0]              level_after;
    logic                    skip;
    logic                    last_harm;
    logic                    term_now;
    logic signed [ACC_W-1:0] shifted;
    logic signed [15:0]      mix_sat;

    // A zero count still sweeps harmonic 0; oversize counts clamp to the table depth.
    always_comb begin
        eff_count = i_Harm_Count;
        if (i_Harm_Count == 8'd0) begin
            eff_count = 8'd1;
        end else if (i_Harm_Count > 8'(NUM_HARM)) begin
            eff_count = 8'(NUM_HARM);
        end
    end

`ifdef ODD_HARMONIC_EN
    logic odd_lat;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            odd_lat <= 1'b0;
        end else if (state == IDLE && i_Sample_Tick) begin
            odd_lat <= i_Odd_Only;
        end
    end

    assign skip = odd_lat & o_Harmonic[0];
`else
    logic unused_odd_only;
    assign unused_odd_only = i_Odd_Only;
    assign skip = 1'b0;
`endif

    always_comb begin
        product     = sample_reg * $signed({1'b0, level});
        product_ext = {{(ACC_W - 25){product[24]}}, product};
        level_dec   = (level > decay_lat) ? (level - decay_lat) : 8'd0;
        level_after = (too_high_reg || skip) ? level : level_dec;
        last_harm   = ({1'b0, o_Harmonic} + 9'd1) >= {1'b0, count_lat};
        term_now    = too_high_reg || (level_after == 8'd0) || last_harm;
    end

    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        if (shifted > MAX16) begin
            mix_sat = 16'sd32767;
        end else if (shifted < MIN16) begin
            mix_sat = -16'sd32768;
        end else begin
            mix_sat = shifted[15:0];
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (i_Sample_Tick) next_state = WAIT_RDY;
            WAIT_RDY: if (i_Sample_Ready) next_state = SETTLE;
            SETTLE:   if (settle_cnt == '0) next_state = MAC;
            MAC:      next_state = ADVANCE;
            ADVANCE:  next_state = PULSE;
            PULSE:    next_state = terminate ? FINISH : WAIT_RDY;
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        o_Next_Sample = (state == PULSE);
        o_Mix_Valid   = (state == FINISH);
    end

    // The mix register loads on the way into FINISH so it is stable while o_Mix_Valid is high.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            acc          <= '0;
            level        <= 8'd255;
            count_lat    <= 8'd0;
            decay_lat    <= 8'd0;
            settle_cnt   <= '0;
            sample_reg   <= '0;
            too_high_reg <= 1'b0;
            terminate    <= 1'b0;
            o_Harmonic   <= 8'd0;
            o_Mix        <= '0;
            o_Overrun    <= 1'b0;
        end else begin
            if (i_Sample_Tick && state != IDLE) begin
                o_Overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_Sample_Tick) begin
                        acc        <= '0;
                        level      <= 8'd255;
                        count_lat  <= eff_count;
                        decay_lat  <= i_Decay;
                        terminate  <= 1'b0;
                        o_Harmonic <= 8'd0;
                    end
                end
                WAIT_RDY: begin
                    if (i_Sample_Ready) begin
                        settle_cnt <= CNT_W'(LUT_LATENCY - 1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        sample_reg   <= i_Sample_Value;
                        too_high_reg <= i_Freq_Too_High;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                MAC: begin
                    if (!too_high_reg && !skip) begin
                        acc   <= acc + product_ext;
                        level <= level_dec;
                    end
                    terminate <= term_now;
                end
                ADVANCE: begin
                    o_Harmonic <= terminate ? 8'd0 : (o_Harmonic + 8'd1);
                end
                PULSE: begin
                    if (terminate) begin
                        o_Mix <= mix_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Self-checking bench for harmonic_scheduler: directed table, hand sequences for reset and
// overrun, and randomized sweeps against a behavioural sweep model. Honours ODD_HARMONIC_EN.
module tb_harmonic_scheduler;

`ifdef ODD_HARMONIC_EN
    localparam bit oddFeature = 1'b1;
`else
    localparam bit oddFeature = 1'b0;
`endif

    logic               clock;
    logic               resetN;
    logic               sampleTick;
    logic [7:0]         harmCount;
    logic [7:0]         decay;
    logic               oddOnly;
    logic               sampleReady;
    logic signed [15:0] sampleValue;
    logic               freqTooHigh;
    logic [7:0]         harmonic;
    logic               nextSample;
    logic signed [15:0] mixOut;
    logic               mixValid;
    logic               overrun;

    logic signed [15:0] sampTab [64];
    bit                 thTab   [64];

    int tests;
    int failures;
    int pulseTotal;
    int validTotal;
    int consecTotal;
    int lastPulseHarm;
    bit prevNs;

    typedef struct {
        string name;
        int    count;
        int    decayVal;
        bit    odd;
        int    sample;
        int    thIdx;
        int    expMix;
        int    expPulses;
    } vec_t;

    harmonic_scheduler dut (
        .i_Clock        (clock),
        .i_Reset_n      (resetN),
        .i_Sample_Tick  (sampleTick),
        .i_Harm_Count   (harmCount),
        .i_Decay        (decay),
        .i_Odd_Only     (oddOnly),
        .i_Sample_Ready (sampleReady),
        .i_Sample_Value (sampleValue),
        .i_Freq_Too_High(freqTooHigh),
        .o_Harmonic     (harmonic),
        .o_Next_Sample  (nextSample),
        .o_Mix          (mixOut),
        .o_Mix_Valid    (mixValid),
        .o_Overrun      (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign sampleValue = sampTab[harmonic[5:0]];
    assign freqTooHigh = thTab[harmonic[5:0]];

    // Datapath stand-in: drops ready on each consumed sample and reloads after a short random delay.
    initial begin
        sampleReady = 1'b1;
        forever begin
            @(negedge clock);
            if (nextSample) begin
                sampleReady = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                sampleReady = 1'b1;
            end
        end
    end

    initial begin
        pulseTotal    = 0;
        validTotal    = 0;
        consecTotal   = 0;
        lastPulseHarm = -1;
        prevNs        = 1'b0;
        forever begin
            @(negedge clock);
            if (nextSample) begin
                pulseTotal++;
                lastPulseHarm = int'(harmonic);
                if (prevNs) consecTotal++;
            end
            prevNs = nextSample;
            if (mixValid) validTotal++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sample, input int thIdx);
        for (int i = 0; i < 64; i++) begin
            sampTab[i] = 16'(sample);
            thTab[i]   = (i == thIdx);
        end
    endtask

    function automatic void refModel(input int count, input int decayVal, input bit odd,
                                     output int mix, output int pulses);
        int     eff;
        int     level;
        int     h;
        bit     done;
        bit     skip;
        longint acc;
        eff    = (count == 0) ? 1 : ((count > 64) ? 64 : count);
        acc    = 0;
        level  = 255;
        pulses = 0;
        done   = 1'b0;
        h      = 0;
        while (!done) begin
            pulses++;
            if (thTab[h]) begin
                done = 1'b1;
            end else begin
                skip = oddFeature && odd && (h % 2 == 1);
                if (!skip) begin
                    acc   = acc + longint'(sampTab[h]) * level;
                    level = (level > decayVal) ? level - decayVal : 0;
                    if (level == 0) done = 1'b1;
                end
                if (h + 1 >= eff) done = 1'b1;
            end
            h++;
        end
        acc = acc >>> 10;
        if (acc > 32767) mix = 32767;
        else if (acc < -32768) mix = -32768;
        else mix = int'(acc);
    endfunction

    task automatic runSweep(input int count, input int decayVal, input bit odd, input int extraTick,
                            output int mix, output int pulses, output int valids,
                            output int lastHarm, output bit timedOut);
        int p0;
        int v0;
        bit seen;
        p0       = pulseTotal;
        v0       = validTotal;
        seen     = 1'b0;
        mix      = 0;
        @(negedge clock);
        harmCount  = 8'(count);
        decay      = 8'(decayVal);
        oddOnly    = odd;
        sampleTick = 1'b1;
        @(negedge clock);
        sampleTick = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clock);
            sampleTick = (c == extraTick);
            if (mixValid) begin
                seen = 1'b1;
                mix  = mixOut;
            end
        end
        sampleTick = 1'b0;
        timedOut   = !seen;
        repeat (3) @(negedge clock);
        pulses   = pulseTotal - p0;
        valids   = validTotal - v0;
        lastHarm = lastPulseHarm;
    endtask

    task automatic checkSweep(input string name, input int count, input int decayVal, input bit odd,
                              input int extraTick, input int expMix, input int expPulses);
        int mix;
        int pulses;
        int valids;
        int lastHarm;
        bit timedOut;
        runSweep(count, decayVal, odd, extraTick, mix, pulses, valids, lastHarm, timedOut);
        checkOutput({name, " timeout"}, int'(timedOut), 0);
        checkOutput({name, " mix"}, mix, expMix);
        checkOutput({name, " pulses"}, pulses, expPulses);
        checkOutput({name, " mix_valid count"}, valids, 1);
        checkOutput({name, " final harmonic"}, lastHarm, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int  expMix;
        int  expPulses;
        int  v0;
        bit  reached;
        tests      = 0;
        failures   = 0;
        resetN     = 1'b0;
        sampleTick = 1'b0;
        harmCount  = 8'd0;
        decay      = 8'd0;
        oddOnly    = 1'b0;
        applyStimulus(0, -1);

        vecs.push_back('{"count4 const",    4,   0,   1'b0, 1000,   -1, 996,    4});
        vecs.push_back('{"too_high idx2",   8,   0,   1'b0, 1000,    2, 498,    3});
        vecs.push_back('{"decay128 neg",    8,   128, 1'b0, -32768, -1, -12224, 2});
        vecs.push_back('{"sat positive",    64,  0,   1'b0, 32767,  -1, 32767,  64});
        vecs.push_back('{"sat negative",    64,  0,   1'b0, -32768, -1, -32768, 64});
        vecs.push_back('{"count0 as 1",     0,   0,   1'b0, 1000,   -1, 249,    1});
        vecs.push_back('{"count clamp",     200, 0,   1'b0, 100,    -1, 1593,   64});
        vecs.push_back('{"decay255",        8,   255, 1'b0, 1000,   -1, 249,    1});
        vecs.push_back('{"too_high idx0",   8,   0,   1'b0, 1000,    0, 0,      1});
        vecs.push_back('{"odd_only count4", 4,   0,   1'b1, 1000,   -1, oddFeature ? 498 : 996, 4});

        repeat (3) @(negedge clock);
        checkOutput("reset harmonic", int'(harmonic), 0);
        checkOutput("reset next_sample", int'(nextSample), 0);
        checkOutput("reset mix", int'(mixOut), 0);
        checkOutput("reset mix_valid", int'(mixValid), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sample, vecs[i].thIdx);
            checkSweep(vecs[i].name, vecs[i].count, vecs[i].decayVal, vecs[i].odd, -1,
                       vecs[i].expMix, vecs[i].expPulses);
        end
        checkOutput("overrun idle after table", int'(overrun), 0);

        // Reset in the middle of a sweep, once the index has reached 3.
        applyStimulus(1000, -1);
        @(negedge clock);
        harmCount  = 8'd8;
        decay      = 8'd0;
        oddOnly    = 1'b0;
        sampleTick = 1'b1;
        @(negedge clock);
        sampleTick = 1'b0;
        reached    = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            @(negedge clock);
            if (harmonic == 8'd3) reached = 1'b1;
        end
        checkOutput("reached index 3", int'(reached), 1);
        v0     = validTotal;
        resetN = 1'b0;
        #1;
        checkOutput("midreset harmonic", int'(harmonic), 0);
        checkOutput("midreset next_sample", int'(nextSample), 0);
        checkOutput("midreset mix", int'(mixOut), 0);
        checkOutput("midreset mix_valid", int'(mixValid), 0);
        repeat (4) @(negedge clock);
        resetN = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("no mix_valid after abort", validTotal - v0, 0);
        checkSweep("post-reset sweep", 4, 0, 1'b0, -1, 996, 4);

        // A second tick while busy flags overrun and leaves the sweep undisturbed.
        checkSweep("overrun sweep", 8, 0, 1'b0, 6, 1992, 8);
        checkOutput("overrun set", int'(overrun), 1);
        checkSweep("after overrun", 4, 0, 1'b0, -1, 996, 4);
        checkOutput("overrun sticky", int'(overrun), 1);

        for (int r = 0; r < 20; r++) begin
            int count;
            int decayVal;
            bit odd;
            for (int i = 0; i < 64; i++) begin
                sampTab[i] = 16'($urandom);
                thTab[i]   = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) thTab[$urandom_range(0, 63)] = 1'b1;
            count = $urandom_range(0, 70);
            case ($urandom_range(0, 2))
                0:       decayVal = 0;
                1:       decayVal = $urandom_range(0, 20);
                default: decayVal = $urandom_range(0, 255);
            endcase
            odd = 1'($urandom_range(0, 1));
            refModel(count, decayVal, odd, expMix, expPulses);
            checkSweep($sformatf("random %0d", r), count, decayVal, odd, -1, expMix, expPulses);
        end

        checkOutput("no back-to-back next_sample", consecTotal, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
